// File: rtl/camera_config_seq.sv
// camera_config_seq: sensor bring-up sequencer.
// Runs a timed power-up (cam_pwdn release, then cam_reset release), then walks
// an external register table, issuing each entry as an SCCB write.
// Table words are {reg_addr, reg_data}. reg_addr all-ones marks a control entry:
// data 8'hFF ends the table, any other data is a delay in milliseconds.
// A NACKed write is re-issued up to MAX_RETRY times before the run aborts.
// Ports:
//   clk, rst_n, clk_en        clock, async active-low reset, clock enable
//   start                     request a run (ignored while busy)
//   rom_addr / rom_data       table address out, table word in (1 clk_en cycle latency)
//   sccb_start/addr/data      write request to the SCCB master
//   sccb_ready/done/nack      SCCB master status
//   cam_pwdn, cam_reset       sensor power-down (active high), reset (active low)
//   busy, done, error         run status levels
//   err_index                 table index of the failing entry
module camera_config_seq #(
    parameter int unsigned CLK_FREQ   = 25000000,
    parameter int unsigned REG_ADDR_W = 8,
    parameter int unsigned ROM_AW     = 8,
    parameter int unsigned T_PWDN_MS  = 5,
    parameter int unsigned T_RST_MS   = 20,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned AUTO_START = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic                    start,
    output logic [ROM_AW-1:0]       rom_addr,
    input  logic [REG_ADDR_W+7:0]   rom_data,
    output logic                    sccb_start,
    output logic [REG_ADDR_W-1:0]   sccb_addr,
    output logic [7:0]              sccb_data,
    input  logic                    sccb_ready,
    input  logic                    sccb_done,
    input  logic                    sccb_nack,
    output logic                    cam_pwdn,
    output logic                    cam_reset,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ROM_AW-1:0]       err_index
);

    localparam int unsigned TICK   = (CLK_FREQ / 1000 < 1) ? 1 : CLK_FREQ / 1000;
    localparam int unsigned TICK_W = (TICK < 2) ? 1 : $clog2(TICK);
    localparam int unsigned MS_W   = 16;
    localparam int unsigned RTY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned AUTO_W = 7;
    localparam logic [REG_ADDR_W-1:0] A_ONES   = '1;
    localparam logic [ROM_AW-1:0]     LAST_IDX = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_PWR_UP, S_RST_REL, S_FETCH, S_WAIT_ROM, S_DECODE,
        S_ISSUE, S_WAIT_XFER, S_DELAY, S_DONE, S_ERROR
    } state_t;

    state_t                  state;
    logic                    start_q;
    logic [TICK_W-1:0]       tick;
    logic [MS_W-1:0]         ms_left;
    logic [RTY_W-1:0]        retry;
    logic [AUTO_W-1:0]       auto_cnt;
    logic                    auto_armed;
    logic [REG_ADDR_W-1:0]   ent_addr;
    logic [7:0]              ent_data;

    logic tick_wrap;
    logic ms_exp;
    logic auto_fire;

    // Timer expires on the last tick of the final millisecond; a zero load expires at once.
    assign tick_wrap = (tick == TICK_W'(TICK - 1));
    assign ms_exp    = (ms_left == '0) || ((ms_left == MS_W'(1)) && tick_wrap);
    assign auto_fire = auto_armed && (auto_cnt == '0);

    // Request is only visible on enabled cycles so the master sees exactly one pulse.
    assign sccb_start = start_q & clk_en;

    // Sequencer state, timers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rom_addr   <= '0;
            start_q    <= 1'b0;
            sccb_addr  <= '0;
            sccb_data  <= '0;
            cam_pwdn   <= 1'b1;
            cam_reset  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_index  <= '0;
            retry      <= '0;
            tick       <= '0;
            ms_left    <= '0;
            auto_cnt   <= AUTO_W'(99);
            auto_armed <= (AUTO_START != 0);
            ent_addr   <= '0;
            ent_data   <= '0;
        end else if (clk_en) begin
            if (auto_armed && auto_cnt != '0) begin
                auto_cnt <= auto_cnt - AUTO_W'(1);
            end
            unique case (state)
                S_IDLE: begin
                    if (start || auto_fire) begin
                        auto_armed <= 1'b0;
                        cam_pwdn   <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        ms_left    <= MS_W'(T_PWDN_MS);
                        tick       <= '0;
                        state      <= S_PWR_UP;
                    end
                end
                S_PWR_UP: begin
                    if (ms_exp) begin
                        cam_reset <= 1'b1;
                        ms_left   <= MS_W'(T_RST_MS);
                        tick      <= '0;
                        state     <= S_RST_REL;
                    end else begin
                        tick <= tick_wrap ? '0 : tick + TICK_W'(1);
                        if (tick_wrap) ms_left <= ms_left - MS_W'(1);
                    end
                end
                S_RST_REL: begin
                    if (ms_exp) begin
                        rom_addr <= '0;
                        retry    <= '0;
                        state    <= S_FETCH;
                    end else begin
                        tick <= tick_wrap ? '0 : tick + TICK_W'(1);
                        if (tick_wrap) ms_left <= ms_left - MS_W'(1);
                    end
                end
                S_FETCH:    state <= S_WAIT_ROM;
                S_WAIT_ROM: state <= S_DECODE;
                S_DECODE: begin
                    ent_addr <= rom_data[REG_ADDR_W+7:8];
                    ent_data <= rom_data[7:0];
                    if (rom_data[REG_ADDR_W+7:8] == A_ONES) begin
                        if (rom_data[7:0] == 8'hFF) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            ms_left <= MS_W'(rom_data[7:0]);
                            tick    <= '0;
                            state   <= S_DELAY;
                        end
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (sccb_ready) begin
                        start_q   <= 1'b1;
                        sccb_addr <= ent_addr;
                        sccb_data <= ent_data;
                        state     <= S_WAIT_XFER;
                    end
                end
                S_WAIT_XFER: begin
                    start_q <= 1'b0;
                    if (sccb_done) begin
                        if (!sccb_nack) begin
                            retry <= '0;
                            // Last table slot finished without an END entry: no wrap.
                            if (rom_addr == LAST_IDX) begin
                                error     <= 1'b1;
                                err_index <= LAST_IDX;
                                busy      <= 1'b0;
                                state     <= S_ERROR;
                            end else begin
                                rom_addr <= rom_addr + ROM_AW'(1);
                                state    <= S_FETCH;
                            end
                        end else if (retry < RTY_W'(MAX_RETRY)) begin
                            retry <= retry + RTY_W'(1);
                            state <= S_ISSUE;
                        end else begin
                            error     <= 1'b1;
                            err_index <= rom_addr;
                            busy      <= 1'b0;
                            state     <= S_ERROR;
                        end
                    end
                end
                S_DELAY: begin
                    if (ms_exp) begin
                        if (rom_addr == LAST_IDX) begin
                            error     <= 1'b1;
                            err_index <= LAST_IDX;
                            busy      <= 1'b0;
                            state     <= S_ERROR;
                        end else begin
                            rom_addr <= rom_addr + ROM_AW'(1);
                            state    <= S_FETCH;
                        end
                    end else begin
                        tick <= tick_wrap ? '0 : tick + TICK_W'(1);
                        if (tick_wrap) ms_left <= ms_left - MS_W'(1);
                    end
                end
                S_DONE, S_ERROR: begin
                    // Rerun skips the power sequence; pins are already released.
                    if (start) begin
                        done     <= 1'b0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        rom_addr <= '0;
                        retry    <= '0;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_config_seq.sv
// tb_camera_config_seq: directed bench for camera_config_seq.
// Instance A: 8-bit addresses, 8-entry table, auto start, retry/error/overrun/reset/clk_en cases.
// Instance B: 16-bit addresses with an in-table delay.
module tb_camera_config_seq;

    logic clk;
    logic rst_n;
    logic clk_en;
    logic en_div4;
    logic [1:0] en_ph;

    // instance A signals
    logic        start_a;
    logic [2:0]  rom_addr_a;
    logic [15:0] rom_q_a;
    logic        sccb_start_a;
    logic [7:0]  sccb_addr_a;
    logic [7:0]  sccb_data_a;
    logic        sready_a, sdone_a, snack_a;
    logic        cam_pwdn_a, cam_reset_a, busy_a, done_a, error_a;
    logic [2:0]  err_index_a;

    // instance B signals
    logic        start_b;
    logic [3:0]  rom_addr_b;
    logic [23:0] rom_q_b;
    logic        sccb_start_b;
    logic [15:0] sccb_addr_b;
    logic [7:0]  sccb_data_b;
    logic        sready_b, sdone_b, snack_b;
    logic        cam_pwdn_b, cam_reset_b, busy_b, done_b, error_b;
    logic [3:0]  err_index_b;

    logic [15:0] tbl_a [8];
    logic [23:0] tbl_b [16];

    int checks = 0;
    int errors = 0;

    // slave A state and logs
    int          cnt_a;
    int          ecyc, ccyc;
    logic [7:0]  cur_addr_a;
    logic [7:0]  nack_addr;
    int          nack_lim, nack_base, nack_seen;
    logic [7:0]  log_a_addr [64];
    logic [7:0]  log_a_data [64];
    int          log_a_e [64];
    int          log_a_c [64];
    int          log_a_n = 0;

    // slave B state and logs
    int          cnt_b;
    logic [15:0] log_b_addr [8];
    logic [7:0]  log_b_data [8];
    int          log_b_e [8];
    int          done_b_e [8];
    int          log_b_n = 0;
    int          done_b_n = 0;

    // pin monitor
    logic prev_pwdn, prev_rst;
    int   pwdn_e, pwdn_c, rrise_e, rrise_c;
    int   rfall_n = 0;

    int base, rf;

    camera_config_seq #(
        .CLK_FREQ(10000), .REG_ADDR_W(8), .ROM_AW(3), .T_PWDN_MS(5),
        .T_RST_MS(20), .MAX_RETRY(3), .AUTO_START(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start_a),
        .rom_addr(rom_addr_a), .rom_data(rom_q_a),
        .sccb_start(sccb_start_a), .sccb_addr(sccb_addr_a), .sccb_data(sccb_data_a),
        .sccb_ready(sready_a), .sccb_done(sdone_a), .sccb_nack(snack_a),
        .cam_pwdn(cam_pwdn_a), .cam_reset(cam_reset_a),
        .busy(busy_a), .done(done_a), .error(error_a), .err_index(err_index_a)
    );

    camera_config_seq #(
        .CLK_FREQ(10000), .REG_ADDR_W(16), .ROM_AW(4), .T_PWDN_MS(1),
        .T_RST_MS(1), .MAX_RETRY(3), .AUTO_START(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start_b),
        .rom_addr(rom_addr_b), .rom_data(rom_q_b),
        .sccb_start(sccb_start_b), .sccb_addr(sccb_addr_b), .sccb_data(sccb_data_b),
        .sccb_ready(sready_b), .sccb_done(sdone_b), .sccb_nack(snack_b),
        .cam_pwdn(cam_pwdn_b), .cam_reset(cam_reset_b),
        .busy(busy_b), .done(done_b), .error(error_b), .err_index(err_index_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // clock enable: always on, or one enabled edge in four
    always @(negedge clk) begin
        if (en_div4) begin
            en_ph  = en_ph + 2'd1;
            clk_en = (en_ph == 2'd0);
        end else begin
            en_ph  = 2'd0;
            clk_en = 1'b1;
        end
    end

    // registered table ROMs
    always @(posedge clk) begin
        if (clk_en) begin
            rom_q_a <= tbl_a[rom_addr_a];
            rom_q_b <= tbl_b[rom_addr_b];
        end
    end

    // SCCB slave A: 3 enabled cycles per transfer, NACK policy by address
    assign sready_a = (cnt_a == 0);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a   <= 0;
            sdone_a <= 1'b0;
            snack_a <= 1'b0;
            ecyc    <= 0;
            ccyc    <= 0;
        end else begin
            ccyc <= ccyc + 1;
            if (clk_en) begin
                ecyc    <= ecyc + 1;
                sdone_a <= 1'b0;
                snack_a <= 1'b0;
                if (cnt_a != 0) begin
                    cnt_a <= cnt_a - 1;
                    if (cnt_a == 1) begin
                        sdone_a <= 1'b1;
                        if (cur_addr_a == nack_addr &&
                            (nack_lim == 255 || (nack_seen - nack_base) < nack_lim)) begin
                            snack_a   <= 1'b1;
                            nack_seen <= nack_seen + 1;
                        end
                    end
                end else if (sccb_start_a) begin
                    cnt_a      <= 3;
                    cur_addr_a <= sccb_addr_a;
                    if (log_a_n < 64) begin
                        log_a_addr[log_a_n] <= sccb_addr_a;
                        log_a_data[log_a_n] <= sccb_data_a;
                        log_a_e[log_a_n]    <= ecyc;
                        log_a_c[log_a_n]    <= ccyc;
                        log_a_n             <= log_a_n + 1;
                    end
                end
            end
        end
    end

    // SCCB slave B: always ACKs
    assign sready_b = (cnt_b == 0);
    assign snack_b  = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_b   <= 0;
            sdone_b <= 1'b0;
        end else if (clk_en) begin
            sdone_b <= 1'b0;
            if (cnt_b != 0) begin
                cnt_b <= cnt_b - 1;
                if (cnt_b == 1) begin
                    sdone_b <= 1'b1;
                    if (done_b_n < 8) begin
                        done_b_e[done_b_n] <= ecyc;
                        done_b_n           <= done_b_n + 1;
                    end
                end
            end else if (sccb_start_b) begin
                cnt_b <= 3;
                if (log_b_n < 8) begin
                    log_b_addr[log_b_n] <= sccb_addr_b;
                    log_b_data[log_b_n] <= sccb_data_b;
                    log_b_e[log_b_n]    <= ecyc;
                    log_b_n             <= log_b_n + 1;
                end
            end
        end
    end

    // pin event monitor for instance A
    always @(negedge clk) begin
        if (prev_pwdn && !cam_pwdn_a) begin
            pwdn_e = ecyc;
            pwdn_c = ccyc;
        end
        if (!prev_rst && cam_reset_a) begin
            rrise_e = ecyc;
            rrise_c = ccyc;
        end
        if (prev_rst && !cam_reset_a && rst_n) rfall_n = rfall_n + 1;
        prev_pwdn = cam_pwdn_a;
        prev_rst  = cam_reset_a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fin_a(input int budget);
        int n = 0;
        while (!(done_a || error_a) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("fin_a_in_time", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_log_a(input int k, input int budget);
        int n = 0;
        while (log_a_n < k && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("log_a_in_time", 32'(n < budget), 32'd1);
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    function automatic int count_addr(input int from, input logic [7:0] a);
        int c = 0;
        for (int i = from; i < log_a_n; i++) if (log_a_addr[i] == a) c++;
        return c;
    endfunction

    task automatic fill_a(input logic [15:0] fill);
        for (int i = 0; i < 8; i++) tbl_a[i] = fill;
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_sccb_start"}, 32'(sccb_start_a), 32'd0);
        chk({tag, "_cam_pwdn"},   32'(cam_pwdn_a),   32'd1);
        chk({tag, "_cam_reset"},  32'(cam_reset_a),  32'd0);
        chk({tag, "_busy"},       32'(busy_a),       32'd0);
        chk({tag, "_done_err"},   32'({done_a, error_a}), 32'd0);
        chk({tag, "_rom_addr"},   32'(rom_addr_a),   32'd0);
        chk({tag, "_sccb_ad"},    32'({sccb_addr_a, sccb_data_a}), 32'd0);
        chk({tag, "_err_index"},  32'(err_index_a),  32'd0);
    endtask

    initial begin
        int gap;
        int n;
        rst_n     = 1'b0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        en_div4   = 1'b0;
        en_ph     = 2'd0;
        clk_en    = 1'b1;
        nack_addr = 8'h00;
        nack_lim  = 0;
        nack_base = 0;
        nack_seen = 0;
        prev_pwdn = 1'b1;
        prev_rst  = 1'b0;
        pwdn_e = 0; pwdn_c = 0; rrise_e = 0; rrise_c = 0;

        // basic 8-bit table, auto start
        fill_a(16'hFFFF);
        tbl_a[0] = 16'h1280;
        tbl_a[1] = 16'h1101;
        tbl_a[2] = 16'hFFFF;
        for (int i = 0; i < 16; i++) tbl_b[i] = 24'hFFFFFF;
        tbl_b[0] = 24'h300882;
        tbl_b[1] = 24'hFFFF0A;
        tbl_b[2] = 24'h310303;
        tbl_b[3] = 24'hFFFFFF;

        repeat (3) @(negedge clk);
        check_reset_a("rst");
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("pre_auto_idle", 32'({busy_a, cam_pwdn_a}), 32'b01);

        base = log_a_n;
        wait_fin_a(2000);
        chk("pwdn_fall_cycle", 32'(pwdn_e), 32'd100);
        chk("rst_rise_cycle",  32'(rrise_e), 32'd150);
        chk("run1_issues",     32'(log_a_n - base), 32'd2);
        chk("run1_w0", 32'({log_a_addr[base], log_a_data[base]}), 32'h1280);
        chk("run1_w1", 32'({log_a_addr[base+1], log_a_data[base+1]}), 32'h1101);
        gap = log_a_e[base] - rrise_e;
        chk("run1_rst_to_first_ge20ms", 32'(gap >= 200 && gap <= 210), 32'd1);
        chk("run1_start_gap", 32'(log_a_e[base+1] - log_a_e[base]), 32'd9);
        chk("run1_status", 32'({done_a, error_a, busy_a}), 32'b100);

        // 16-bit addresses with a 10 ms table delay
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!(done_b || error_b) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("fin_b_in_time", 32'(n < 2000), 32'd1);
        chk("b_issues", 32'(log_b_n), 32'd2);
        chk("b_w0", 32'({log_b_addr[0], log_b_data[0]}), 32'h300882);
        chk("b_w1", 32'({log_b_addr[1], log_b_data[1]}), 32'h310303);
        gap = log_b_e[1] - done_b_e[0];
        chk("b_delay_ge10ms", 32'(gap >= 100 && gap <= 120), 32'd1);
        chk("b_status", 32'({done_b, error_b, busy_b, cam_pwdn_b, cam_reset_b}), 32'b10001);
        chk("b_err_index", 32'(err_index_b), 32'd0);

        // entry 2 NACKed twice then ACKed
        fill_a(16'hFFFF);
        tbl_a[0] = 16'h2001;
        tbl_a[1] = 16'h2102;
        tbl_a[2] = 16'h2203;
        nack_addr = 8'h22;
        nack_lim  = 2;
        nack_base = nack_seen;
        base = log_a_n;
        rf = rfall_n;
        pulse_start_a();
        wait_fin_a(2000);
        chk("retry_issues", 32'(log_a_n - base), 32'd5);
        chk("retry_entry2", 32'(count_addr(base, 8'h22)), 32'd3);
        chk("retry_status", 32'({done_a, error_a}), 32'b10);
        chk("retry_pins", 32'({cam_pwdn_a, cam_reset_a, 32'(rfall_n - rf) == 0}), 32'b011);

        // entry 4 always NACKed
        fill_a(16'hFFFF);
        for (int i = 0; i < 5; i++) tbl_a[i] = {8'h30 + 8'(i), 8'h55};
        nack_addr = 8'h34;
        nack_lim  = 255;
        base = log_a_n;
        pulse_start_a();
        wait_fin_a(2000);
        chk("nack_entry4_issues", 32'(count_addr(base, 8'h34)), 32'd4);
        chk("nack_total_issues", 32'(log_a_n - base), 32'd8);
        chk("nack_status", 32'({done_a, error_a, busy_a}), 32'b010);
        chk("nack_err_index", 32'(err_index_a), 32'd4);

        // rerun after error restarts at index 0, no power sequence
        fill_a(16'hFFFF);
        tbl_a[0] = 16'h4000;
        nack_lim = 0;
        base = log_a_n;
        rf = rfall_n;
        pulse_start_a();
        wait_fin_a(2000);
        chk("rerun_first_addr", 32'(log_a_addr[base]), 32'h40);
        chk("rerun_issues", 32'(log_a_n - base), 32'd1);
        chk("rerun_status", 32'({done_a, error_a}), 32'b10);
        chk("rerun_reset_held", 32'({cam_reset_a, 32'(rfall_n - rf) == 0}), 32'b11);

        // no END entry: overrun
        for (int i = 0; i < 8; i++) tbl_a[i] = {8'h50 + 8'(i), 8'(i)};
        base = log_a_n;
        pulse_start_a();
        wait_fin_a(2000);
        chk("overrun_issues", 32'(log_a_n - base), 32'd8);
        chk("overrun_last", 32'(log_a_addr[log_a_n-1]), 32'h57);
        chk("overrun_status", 32'({done_a, error_a}), 32'b01);
        chk("overrun_err_index", 32'(err_index_a), 32'd7);

        // reset while a transfer is outstanding
        fill_a(16'hFFFF);
        tbl_a[0] = 16'h1280;
        tbl_a[1] = 16'hFF0A;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!sccb_start_a && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("xfer_start_seen", 32'(n < 2000), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_a("rst_xfer");
        @(negedge clk);
        rst_n = 1'b1;

        // reset during a table delay
        base = log_a_n;
        wait_log_a(base + 1, 2000);
        repeat (40) @(negedge clk);
        chk("in_delay", 32'({busy_a, rom_addr_a}), 32'b1001);
        #2 rst_n = 1'b0;
        #1 check_reset_a("rst_delay");

        // 1:4 clock enable: same writes, timing scaled by four
        en_div4 = 1'b1;
        fill_a(16'hFFFF);
        tbl_a[0] = 16'h1280;
        tbl_a[1] = 16'h1101;
        @(negedge clk);
        rst_n = 1'b1;
        base = log_a_n;
        wait_fin_a(8000);
        chk("div4_issues", 32'(log_a_n - base), 32'd2);
        chk("div4_w0", 32'({log_a_addr[base], log_a_data[base]}), 32'h1280);
        chk("div4_w1", 32'({log_a_addr[base+1], log_a_data[base+1]}), 32'h1101);
        chk("div4_start_gap", 32'(log_a_c[base+1] - log_a_c[base]), 32'd36);
        chk("div4_pwdn_to_rst", 32'(rrise_c - pwdn_c), 32'd200);
        chk("div4_status", 32'({done_a, error_a}), 32'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/camera_config_seq.md
Name: camera_config_seq

Overview:
Parametrised camera bring-up sequencer that replaces fixed-constant power/reset pins and a fixed-format 8-bit config walker. It drives the sensor power-down and reset pins through a timed power-up sequence. It then walks an external register table and issues writes to an SCCB master, with 8- or 16-bit register addresses, in-table millisecond delays, per-entry NACK retry and error reporting. It sits between the config ROM and the SCCB interface inside the camera configuration subsystem.

Parameters:
CLK_FREQ, 25000000, clk frequency in Hz; ms tick = CLK_FREQ/1000 clk_en-qualified cycles
REG_ADDR_W, 8, sensor register address width (8 or 16)
ROM_AW, 8, table address width; table depth 2^ROM_AW
T_PWDN_MS, 5, wait after cam_pwdn deassert before cam_reset release
T_RST_MS, 20, wait after cam_reset release before first table entry
MAX_RETRY, 3, re-issues of a NACKed entry before error (0 = no retry)
AUTO_START, 1, 1 = begin sequence 100 clk_en cycles after reset without start

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  clock enable; all state/counter updates only when 1
start  in  1  single-cycle request to run sequence
rom_addr  out  ROM_AW  table address
rom_data  in  REG_ADDR_W+8  table word {reg_addr, reg_data}; valid 1 clk_en cycle after rom_addr
sccb_start  out  1  one clk_en-cycle write request
sccb_addr  out  REG_ADDR_W  register address
sccb_data  out  8  register data
sccb_ready  in  1  SCCB master idle
sccb_done  in  1  one-cycle pulse: transaction complete
sccb_nack  in  1  qualified by sccb_done; 1 = slave NACK
cam_pwdn  out  1  sensor power-down, active high
cam_reset  out  1  sensor reset, active low
busy  out  1  sequence in progress
done  out  1  table completed successfully (level)
error  out  1  sequence aborted (level)
err_index  out  ROM_AW  table index of failing entry

Behaviour:
- Reset values: rom_addr=0, sccb_start=0, sccb_addr=0, sccb_data=0, cam_pwdn=1, cam_reset=0, busy=0, done=0, error=0, err_index=0, retry count=0, state IDLE. Reset mid-sequence aborts immediately; sccb_start drops asynchronously.
- Entry decode, with A_ONES = all-ones reg_addr:
  - reg_addr==A_ONES and data==8'hFF: END.
  - reg_addr==A_ONES otherwise: DELAY of data ms; data 0 = no wait.
  - Anything else: WRITE.
- States:
  - IDLE: waits for start, or AUTO_START counter reaching 0.
  - PWR_UP: cam_pwdn=0; waits T_PWDN_MS.
  - RST_REL: cam_reset=1; waits T_RST_MS.
  - FETCH: presents rom_addr.
  - WAIT_ROM: one cycle.
  - DECODE
  - ISSUE: waits sccb_ready=1, pulses sccb_start for exactly one clk_en cycle and latches sccb_addr/sccb_data. These are held stable until sccb_done.
  - WAIT_XFER
  - DELAY: counts ms ticks.
  - DONE
  - ERROR
- Transitions:
  - DECODE: WRITE→ISSUE; DELAY→DELAY; END→DONE.
  - WAIT_XFER, sccb_done & !sccb_nack: rom_addr+1, retry count cleared, →FETCH.
  - WAIT_XFER, sccb_done & sccb_nack & retry<MAX_RETRY: retry+1, →ISSUE with the same entry.
  - WAIT_XFER, sccb_done & sccb_nack & retry==MAX_RETRY: err_index=rom_addr, →ERROR.
  - DELAY expiry: rom_addr+1, →FETCH.
- Table overrun: if entry 2^ROM_AW-1 completes without END, set error=1, err_index=2^ROM_AW-1, →ERROR. No wrap.
- busy=1 in every state except IDLE, DONE and ERROR.
- done and error are mutually exclusive levels, cleared when a new run starts.
- start while busy is ignored.
- start in DONE or ERROR reruns the table from index 0 via FETCH. Power pins stay released; no power sequence.
- AUTO_START fires once per reset. A start that coincides with the auto trigger is a single run.
- sccb_done arriving outside WAIT_XFER is ignored.
- clk_en=0 freezes all state, counters and outputs. sccb_start is asserted only while clk_en=1.

Test Plan:
- REG_ADDR_W=8, AUTO_START=1, table {12 80},{11 01},{FF FF} → cam_pwdn falls at cycle 100+; cam_reset rises 5 ms later; two sccb_start pulses (12/80, 11/01) with first starting ≥20 ms after cam_reset rises; done=1, busy=0.
- REG_ADDR_W=16, table {3008 82},{FFFF 0A},{3103 03},{FFFF FF} → sccb_addr 16'h3008 then 16'h3103; gap between first sccb_done and second sccb_start ≥10 ms (10×CLK_FREQ/1000 clk_en cycles).
- MAX_RETRY=3; slave NACKs entry 2 twice then ACKs → entry 2 issued 3 times total; done=1, error=0.
- MAX_RETRY=3; slave always NACKs entry 4 → 4 issues of entry 4; error=1, err_index=4, done=0; subsequent start reruns from index 0 with cam_reset held at 1.
- ROM_AW=3 table with no END → 8 entries processed; error=1, err_index=7.
- rst_n asserted while in WAIT_XFER and again during DELAY → all outputs return to reset values; clk_en toggled 1:4 during a run → identical sccb_start sequence with timing scaled ×4.
